// File: rtl/alu_op_arbiter_if.sv
// Bundled request, datapath and response signals of alu_op_arbiter.
// Handshake rule for req0, req1 and rsp: a transfer happens on a rising edge where valid and ready are both high; the producer holds valid and payload stable until then.
interface alu_op_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_c;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_c,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  // Requester / datapath / consumer side.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_c,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_arbiter.sv
// Two-requester sequencer for the shared 8-bit gate datapath: IDLE -> ISSUE -> RESP.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 has fixed priority. WIDTH must be a multiple of 4.
module alu_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_arbiter_if.slave    bus,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             any_valid;
  logic             tie_winner;
  logic             grant_id;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_id_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant_id;
    end
  end

  assign tie_winner = ~last_q;
`else
  assign tie_winner = 1'b0;
`endif

  assign any_valid = bus.req0_valid | bus.req1_valid;

  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = tie_winner;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Next-state and accept decode; rst gates accept so readies read 0 during reset.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_valid && !rst) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= grant_id ? bus.req1_op : bus.req0_op;
        a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
        b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
        id_q <= grant_id;
      end
      if (state_q == S_ISSUE) begin
        rsp_data_q <= bus.alu_c;
        rsp_id_q   <= id_q;
      end
    end
  end

  // Datapath operands come straight from the capture registers, so they hold between issues.
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.req0_ready = accept & ~grant_id;
  assign bus.req1_ready = accept &  grant_id;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign busy           = (state_q != S_IDLE);
  assign state_dbg      = state_q;

endmodule
